cisr_row_scheduler: RTL and testbench

- Assigns sparse-matrix rows to NUM_CH parallel channels in CISR order for the decoder.
- Accepts a stream of row lengths and keeps a per-channel countdown of remaining nonzeros.
- On each datapath step, tags every active channel's element with its row index and a last-of-row flag.
- When a channel's row ends, refills that channel with the next row, so the row-length counters are sequenced centrally.

---
 rtl/cisr_pkg.sv | 11 +
 rtl/cisr_row_scheduler_if.sv | 25 ++
 rtl/cisr_ch_counter.sv | 34 +++
 rtl/cisr_row_scheduler.sv | 104 ++++++++++
 tb/tb_cisr_row_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cisr_pkg.sv
// cisr_pkg: shared state encoding, default widths and a priority helper for the CISR row scheduler.
package cisr_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
    localparam int NUM_CH_DEF = 4;
    localparam int LEN_W_DEF = 5;
    localparam int ROW_W_DEF = 16;
    function automatic int unsigned lowest_set(input logic [31:0] v);
        lowest_set = 0;
        for (int i = 31; i >= 0; i--) if (v[i]) lowest_set = i;
    endfunction
endpackage

// File: rtl/cisr_row_scheduler_if.sv
// cisr_row_scheduler_if: row-length stream, step handshake and per-channel tag bus.
interface cisr_row_scheduler_if import cisr_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ROW_W = ROW_W_DEF
);
    logic rl_valid;
    logic [LEN_W-1:0] rl_data;
    logic rl_ready;
    logic step;
    logic step_ready;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH*ROW_W-1:0] ch_row;
    logic [NUM_CH-1:0] ch_last;
    logic empty_row;
    logic [ROW_W-1:0] empty_row_id;
    modport master(
        output rl_valid, rl_data, step,
        input rl_ready, step_ready, ch_active, ch_row, ch_last, empty_row, empty_row_id
    );
    modport slave(
        input rl_valid, rl_data, step,
        output rl_ready, step_ready, ch_active, ch_row, ch_last, empty_row, empty_row_id
    );
endinterface

// File: rtl/cisr_ch_counter.sv
// cisr_ch_counter: one channel's remaining-nonzero countdown plus its row tag.
module cisr_ch_counter import cisr_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic [LEN_W-1:0] load_len,
    input  logic [ROW_W-1:0] load_row,
    input  logic dec,
    output logic active,
    output logic [ROW_W-1:0] row,
    output logic last
);
    logic [LEN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            row <= '0;
            active <= 1'b0;
        end else if (load) begin
            count <= load_len;
            row <= load_row;
            active <= 1'b1;
        end else if (dec && active) begin
            count <= count - LEN_W'(1);
            active <= count != LEN_W'(1);
        end
    end

    assign last = active && count == LEN_W'(1);
endmodule

// File: rtl/cisr_row_scheduler.sv
// cisr_row_scheduler: hands rows to NUM_CH channels in CISR order and tags each step's elements.
// Optional macro CISR_SCHED_STATS_EN adds busy_cycles/stall_cycles counters.
module cisr_row_scheduler import cisr_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [ROW_W-1:0] total_rows,
    output logic done,
`ifdef CISR_SCHED_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] busy_cycles,
`endif
    cisr_row_scheduler_if.slave bus
);
    state_t state, state_nx;
    logic [ROW_W-1:0] total, next_row;
    logic [NUM_CH-1:0] active, last, load;
    logic [ROW_W-1:0] rows [NUM_CH];
    logic busy, kick, rows_left, fill_done, rl_hs, dec;
    int unsigned target;

    assign busy = state == FILL || state == RUN;
    assign kick = start && (state == IDLE || state == DONE);
    assign rows_left = next_row < total;
    assign fill_done = &active || !rows_left;
    assign rl_hs = bus.rl_valid && bus.rl_ready;
    assign dec = bus.step && bus.step_ready;
    assign target = lowest_set(32'(~active));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = total_rows == '0 ? DONE : FILL;
            FILL:       if (fill_done) state_nx = RUN;
            RUN:        if (active == '0 && !rows_left) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Refill and stepping are mutually exclusive: rl_ready needs a free channel, step_ready needs none.
    always_comb begin
        bus.rl_ready = busy && rows_left && !(&active);
        bus.step_ready = busy && fill_done && |active;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            total <= '0;
            next_row <= '0;
            bus.empty_row <= 1'b0;
            bus.empty_row_id <= '0;
        end else begin
            bus.empty_row <= rl_hs && bus.rl_data == '0;
            if (kick) begin
                total <= total_rows;
                next_row <= '0;
            end else if (rl_hs) begin
                next_row <= next_row + ROW_W'(1);
                if (bus.rl_data == '0) bus.empty_row_id <= next_row;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign load[g] = rl_hs && bus.rl_data != '0 && target == 32'(g);
        cisr_ch_counter #(.LEN_W(LEN_W), .ROW_W(ROW_W)) u_ch (
            .clk(clk),
            .reset(reset),
            .load(load[g]),
            .load_len(bus.rl_data),
            .load_row(next_row),
            .dec(dec),
            .active(active[g]),
            .row(rows[g]),
            .last(last[g])
        );
        assign bus.ch_row[g*ROW_W +: ROW_W] = rows[g];
    end

    assign bus.ch_active = active;
    assign bus.ch_last = last;

`ifdef CISR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset || kick) begin
            busy_cycles <= '0;
            stall_cycles <= '0;
        end else if (busy) begin
            busy_cycles <= busy_cycles + 32'd1;
            if (!bus.step_ready) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cisr_row_scheduler.sv
// tb_cisr_row_scheduler: random and directed matrices checked against a timing-free row-assignment model.
module tb_cisr_row_scheduler;
    import cisr_pkg::*;
    localparam int NUM_CH = 4;
    localparam int LEN_W = 5;
    localparam int ROW_W = 16;

    typedef struct {
        logic [NUM_CH-1:0] act;
        logic [NUM_CH*ROW_W-1:0] row;
        logic [NUM_CH-1:0] last;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [ROW_W-1:0] total_rows = '0;
    logic done;
`ifdef CISR_SCHED_STATS_EN
    logic [31:0] stall_cycles, busy_cycles;
`endif

    cisr_row_scheduler_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ROW_W(ROW_W)) bus();

    cisr_row_scheduler #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ROW_W(ROW_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .total_rows(total_rows),
        .done(done),
`ifdef CISR_SCHED_STATS_EN
        .stall_cycles(stall_cycles),
        .busy_cycles(busy_cycles),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    snap_t exp_q[$];
    int exp_empty[$];
    int lens[$];
    bit rl_seen;
    int c;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [63:0] mask_rows(input logic [NUM_CH-1:0] act, input logic [NUM_CH*ROW_W-1:0] r);
        mask_rows = '0;
        for (int i = 0; i < NUM_CH; i++) if (act[i]) mask_rows[i*ROW_W +: ROW_W] = r[i*ROW_W +: ROW_W];
    endfunction

    // Whole-matrix model: fill free channels lowest-first from the row list, then one step snapshot.
    task automatic build_expected(input int total);
        int rem[NUM_CH];
        int rw[NUM_CH];
        int nr = 0;
        int f;
        bit any;
        snap_t s;
        for (int i = 0; i < NUM_CH; i++) begin
            rem[i] = 0;
            rw[i] = 0;
        end
        while (1) begin
            while (nr < total) begin
                f = -1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (rem[i] == 0) f = i;
                if (f < 0) break;
                if (lens[nr] == 0) exp_empty.push_back(nr);
                else begin
                    rem[f] = lens[nr];
                    rw[f] = nr;
                end
                nr++;
            end
            any = 0;
            s.act = '0;
            s.row = '0;
            s.last = '0;
            for (int i = 0; i < NUM_CH; i++) if (rem[i] > 0) begin
                any = 1;
                s.act[i] = 1'b1;
                s.row[i*ROW_W +: ROW_W] = ROW_W'(rw[i]);
                s.last[i] = rem[i] == 1;
                rem[i]--;
            end
            if (!any) break;
            exp_q.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        snap_t s;
        int e;
        if (reset) begin
            if (bus.rl_ready) rl_seen = 1;
            if (bus.step && bus.step_ready) begin
                chk("step_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    s = exp_q.pop_front();
                    chk("ch_active", 64'(bus.ch_active), 64'(s.act));
                    chk("ch_row", mask_rows(bus.ch_active, bus.ch_row), mask_rows(s.act, s.row));
                    chk("ch_last", 64'(bus.ch_last), 64'(s.last));
                end
            end
            if (bus.empty_row) begin
                chk("empty_expected", 64'(exp_empty.size() != 0), 64'd1);
                if (exp_empty.size() != 0) begin
                    e = exp_empty.pop_front();
                    chk("empty_row_id", 64'(bus.empty_row_id), 64'(e));
                end
            end
        end
    end

    // Called at posedge+1; drives one matrix until DONE or until max_steps steps were issued.
    task automatic run_matrix(input int total, input int max_steps, input bit rnd, output int cyc);
        int idx = 0;
        int steps = 0;
        cyc = 0;
        build_expected(total);
        start = 1'b1;
        total_rows = ROW_W'(total);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 3000) begin
            if (done || (max_steps >= 0 && steps >= max_steps)) break;
            bus.rl_valid = idx < total && (!rnd || $urandom_range(0, 3) != 0);
            bus.rl_data = bus.rl_valid ? LEN_W'(lens[idx]) : '0;
            bus.step = bus.step_ready && (max_steps < 0 || steps < max_steps) && (!rnd || $urandom_range(0, 2) != 0);
            if (bus.rl_valid && bus.rl_ready) idx++;
            if (bus.step) steps++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.rl_valid = 1'b0;
        bus.step = 1'b0;
        if (max_steps < 0) begin
            chk("done_reached", 64'(done), 64'd1);
            chk("rows_consumed", 64'(idx), 64'(total));
        end
    endtask

    task automatic finish_checks(input string nm);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_steps_left"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_empties_left"}, 64'(exp_empty.size()), 64'd0);
        chk({nm, "_active"}, 64'(bus.ch_active), 64'd0);
        chk({nm, "_rl_ready"}, 64'(bus.rl_ready), 64'd0);
        chk({nm, "_step_ready"}, 64'(bus.step_ready), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ch_active"}, 64'(bus.ch_active), 64'd0);
        chk({nm, "_ch_row"}, 64'(bus.ch_row), 64'd0);
        chk({nm, "_ch_last"}, 64'(bus.ch_last), 64'd0);
        chk({nm, "_rl_ready"}, 64'(bus.rl_ready), 64'd0);
        chk({nm, "_step_ready"}, 64'(bus.step_ready), 64'd0);
        chk({nm, "_empty_row"}, 64'(bus.empty_row), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rl_valid = 1'b0;
        bus.rl_data = '0;
        bus.step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_zero("por");

        lens = {4, 1, 2, 3};
        run_matrix(4, -1, 0, c);
        finish_checks("basic");

        lens = {1, 1, 5, 5, 2, 3};
        run_matrix(6, -1, 0, c);
        finish_checks("refill");

        lens = {0, 3, 0, 2, 1, 1};
        run_matrix(6, -1, 0, c);
        finish_checks("empty");

        lens = {2, 2};
        run_matrix(2, -1, 0, c);
        chk("done_latency_2rows", 64'(c), 64'd5);
        finish_checks("complete");

        lens.delete();
        rl_seen = 0;
        run_matrix(0, -1, 0, c);
        chk("done_latency_0rows", 64'(c), 64'd0);
        finish_checks("zero");
        chk("zero_rl_ready_seen", 64'(rl_seen), 64'd0);
`ifdef CISR_SCHED_STATS_EN
        chk("zero_busy_cycles", 64'(busy_cycles), 64'd0);
`endif

        lens = {3, 2, 4, 1};
        run_matrix(4, 2, 0, c);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        exp_empty.delete();
        check_zero("mid_reset");
        lens = {2, 1, 3};
        run_matrix(3, -1, 0, c);
        finish_checks("after_reset");

        repeat (25) begin
            int t;
            t = $urandom_range(1, 12);
            lens.delete();
            for (int i = 0; i < t; i++) lens.push_back($urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 7)));
            run_matrix(t, -1, 1, c);
            finish_checks("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
